// File: rtl/phase_sequencer.sv
// Traffic signal phase sequencer: ALL_RED -> GREEN -> YELLOW cycle with actuated gap/max-out, pedestrian walk and flash mode.
// All timing is in prescaler ticks; the prescaler restarts on every state change so each state lasts whole ticks.
module phase_sequencer #(
  parameter int N_PH      = 4,
  parameter int TICK_DIV  = 10000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 30,
  parameter int EXT       = 2,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int TW        = 16
) (
  input  logic                      clk,
  input  logic                      clock_reset,
  input  logic                      en,
  input  logic                      flash_req,
  input  logic [N_PH-1:0]           demand,
  input  logic [N_PH-1:0]           ped_req,
  output logic [2*N_PH-1:0]         light,
  output logic [N_PH-1:0]           ped_walk,
  output logic [$clog2(N_PH)-1:0]   active_phase,
  output logic                      phase_done
);

  localparam int AW = $clog2(N_PH);
  localparam logic [TW-1:0] PRESC_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_ALL_RED, ST_GREEN, ST_YELLOW, ST_FLASH} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   active_q, active_d, next_ph, srch_idx;
  logic [TW-1:0]   presc_q, presc_d, tmr_q, tmr_d, gap_q, gap_d, gap_nx;
  logic [N_PH-1:0] req_q, req_d, pedreq_q, pedreq_d, act_mask;
  logic            walk_q, walk_d, dark_q, dark_d, force0_q, force0_d;
  logic            tick, other_req, gap_out, max_out, green_exit, trans;

  assign tick = en && (presc_q == PRESC_LAST);

  always_comb begin
    act_mask = '0;
    for (int i = 0; i < N_PH; i++) begin
      if (AW'(i) == active_q) act_mask[i] = 1'b1;
    end
  end

  assign other_req = |(req_q & ~act_mask);

  // Gap and green timers are judged on their post-tick values so exits land on tick boundaries.
  assign gap_nx  = demand[active_q] ? '0 :
                   ((tick && gap_q < TW'(EXT)) ? gap_q + TW'(1) : gap_q);
  assign gap_out = tick && other_req && (tmr_q >= TW'(MIN_GREEN - 1)) && (gap_nx == TW'(EXT));
  assign max_out = tick && other_req && (tmr_q >= TW'(MAX_GREEN - 1));
  assign green_exit = !clock_reset && en && (state_q == ST_GREEN) &&
                      (flash_req || gap_out || max_out);

  // Cyclic search from active+1; descending loop lets the nearest requester win.
  always_comb begin
    next_ph  = active_q;
    srch_idx = '0;
    for (int k = N_PH; k >= 1; k--) begin
      srch_idx = AW'((int'(active_q) + k) % N_PH);
      if (req_q[srch_idx]) next_ph = srch_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (clock_reset) begin
      state_q  <= ST_ALL_RED;
      active_q <= '0;
      presc_q  <= '0;
      tmr_q    <= '0;
      gap_q    <= '0;
      req_q    <= '0;
      pedreq_q <= '0;
      walk_q   <= 1'b0;
      dark_q   <= 1'b0;
      force0_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      presc_q  <= presc_d;
      tmr_q    <= tmr_d;
      gap_q    <= gap_d;
      req_q    <= req_d;
      pedreq_q <= pedreq_d;
      walk_q   <= walk_d;
      dark_q   <= dark_d;
      force0_q <= force0_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    presc_d  = en ? ((presc_q == PRESC_LAST) ? '0 : presc_q + TW'(1)) : presc_q;
    tmr_d    = (tick && tmr_q != '1) ? tmr_q + TW'(1) : tmr_q;
    gap_d    = gap_q;
    req_d    = req_q | demand | ped_req;
    pedreq_d = pedreq_q | ped_req;
    walk_d   = walk_q;
    dark_d   = dark_q;
    force0_d = force0_q;
    trans    = 1'b0;
    case (state_q)
      ST_ALL_RED: begin
        if (tick && tmr_q == TW'(ALL_RED - 1)) begin
          trans = 1'b1;
          if (flash_req) begin
            state_d = ST_FLASH;
            dark_d  = 1'b0;
          end else begin
            state_d           = ST_GREEN;
            active_d          = force0_q ? '0 : next_ph;
            walk_d            = pedreq_q[active_d];
            req_d[active_d]   = 1'b0;
            pedreq_d[active_d] = 1'b0;
            force0_d          = 1'b0;
          end
        end
      end
      ST_GREEN: begin
        gap_d = en ? gap_nx : gap_q;
        if (green_exit) begin
          state_d = ST_YELLOW;
          trans   = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (tick && tmr_q == TW'(YELLOW - 1)) begin
          state_d = ST_ALL_RED;
          trans   = 1'b1;
        end
      end
      ST_FLASH: begin
        if (tick) dark_d = ~dark_q;
        // Leaving flash always restarts the sequence at phase 0.
        if (en && !flash_req) begin
          state_d  = ST_ALL_RED;
          force0_d = 1'b1;
          trans    = 1'b1;
        end
      end
      default: state_d = ST_ALL_RED;
    endcase
    if (trans) begin
      presc_d = '0;
      tmr_d   = '0;
      gap_d   = '0;
    end
  end

  always_comb begin
    light      = '0;
    ped_walk   = '0;
    phase_done = green_exit;
    for (int i = 0; i < N_PH; i++) begin
      if (state_q == ST_FLASH) begin
        light[2*i +: 2] = dark_q ? 2'b11 : 2'b10;
      end else if (AW'(i) == active_q) begin
        if (state_q == ST_GREEN) begin
          light[2*i +: 2] = 2'b01;
          ped_walk[i]     = walk_q && (tmr_q < TW'(MIN_GREEN));
        end else if (state_q == ST_YELLOW) begin
          light[2*i +: 2] = 2'b10;
        end
      end
    end
  end

  assign active_phase = active_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus random traffic against an elapsed-cycle reference model.
module tb_phase_sequencer;
  localparam int NP = 4, TD = 4, MING = 5, MAXG = 30, EXTT = 2, YD = 3, ARD = 1;
  localparam int S_AR = 0, S_G = 1, S_Y = 2, S_F = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clock_reset, en, flash_req;
  logic [NP-1:0]   demand, ped_req;
  logic [2*NP-1:0] light;
  logic [NP-1:0]   ped_walk;
  logic [1:0]      active_phase;
  logic            phase_done;

  phase_sequencer #(.N_PH(NP), .TICK_DIV(TD)) dut (
    .clk(clk), .clock_reset(clock_reset), .en(en), .flash_req(flash_req),
    .demand(demand), .ped_req(ped_req), .light(light), .ped_walk(ped_walk),
    .active_phase(active_phase), .phase_done(phase_done)
  );

  int total = 0, bad = 0;
  logic rst_v, en_v, fl_v;
  logic [NP-1:0] dem_v, ped_v;
  logic [14:0] exp_vec, got_vec;

  // Reference model: state kind, owning phase, enabled cycles spent in the state.
  int m_st, m_ph, m_cyc, m_last;
  bit [NP-1:0] m_req, m_ped;
  bit m_walk, m_force0;

  function automatic bit m_other();
    for (int j = 0; j < NP; j++) if (j != m_ph && m_req[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_search(bit [NP-1:0] r);
    for (int k = 1; k <= NP; k++) if (r[(m_ph + k) % NP]) return (m_ph + k) % NP;
    return m_ph;
  endfunction

  function automatic bit m_gexit();
    int gt, gap;
    if (m_st != S_G || rst_v || !en_v) return 1'b0;
    if (fl_v) return 1'b1;
    if (m_cyc % TD != TD - 1 || !m_other()) return 1'b0;
    gt = (m_cyc + 1) / TD;
    if (gt >= MAXG) return 1'b1;
    if (dem_v[m_ph]) return 1'b0;
    gap = gt - (m_last + 1) / TD;
    return (gt >= MING) && (gap >= EXTT);
  endfunction

  task automatic m_outputs();
    logic [2*NP-1:0] el;
    logic [NP-1:0] ew;
    el = '0; ew = '0;
    case (m_st)
      S_G: begin el[2*m_ph +: 2] = 2'b01; ew[m_ph] = m_walk && (m_cyc < MING * TD); end
      S_Y: el[2*m_ph +: 2] = 2'b10;
      S_F: for (int i = 0; i < NP; i++) el[2*i +: 2] = ((m_cyc / TD) % 2 == 1) ? 2'b11 : 2'b10;
      default: el = '0;
    endcase
    exp_vec = {el, ew, 2'(m_ph), m_gexit()};
  endtask

  task automatic m_adv();
    bit ge;
    bit [NP-1:0] oreq, oped;
    int nxt;
    if (rst_v) begin
      m_st = S_AR; m_ph = 0; m_cyc = 0; m_last = -1;
      m_req = '0; m_ped = '0; m_walk = 1'b0; m_force0 = 1'b0;
      return;
    end
    ge = m_gexit(); oreq = m_req; oped = m_ped;
    m_req = m_req | dem_v | ped_v;
    m_ped = m_ped | ped_v;
    if (!en_v) return;
    case (m_st)
      S_AR: if (m_cyc == ARD * TD - 1) begin
              m_cyc = 0;
              if (fl_v) m_st = S_F;
              else begin
                nxt = m_force0 ? 0 : m_search(oreq);
                m_st = S_G; m_ph = nxt; m_walk = oped[nxt];
                m_req[nxt] = 1'b0; m_ped[nxt] = 1'b0; m_force0 = 1'b0; m_last = -1;
              end
            end else m_cyc++;
      S_G:  if (ge) begin m_st = S_Y; m_cyc = 0; end
            else begin if (dem_v[m_ph]) m_last = m_cyc; m_cyc++; end
      S_Y:  if (m_cyc == YD * TD - 1) begin m_st = S_AR; m_cyc = 0; end else m_cyc++;
      default: if (!fl_v) begin m_st = S_AR; m_cyc = 0; m_force0 = 1'b1; end else m_cyc++;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    clock_reset = rst_v; en = en_v; flash_req = fl_v; demand = dem_v; ped_req = ped_v;
    @(negedge clk);
    m_outputs();
    got_vec = {light, ped_walk, active_phase, phase_done};
  endtask

  task automatic do_reset();
    rst_v = 1'b1; en_v = 1'b1; fl_v = 1'b0; dem_v = '0; ped_v = '0;
    repeat (2) begin cycle(); m_adv(); end
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL reset_model n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      if (n < 4) begin
        total++; if (light !== 8'h00) begin bad++; $display("FAIL reset_allred n=%0d light=%h want=00", n, light); end
      end else if (n == 4) begin
        total++; if (light !== 8'h01 || active_phase !== 2'd0) begin
          bad++; $display("FAIL reset_first_green light=%h act=%0d want 01/0", light, active_phase); end
      end
      m_adv();
    end
  endtask

  task automatic test_rest();
    int dn = 0;
    do_reset();
    for (int n = 0; n < 404; n++) begin
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL rest n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      if (phase_done) dn++;
      m_adv();
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL rest_done count=%0d want=0", dn); end
    total++; if (light !== 8'h01) begin bad++; $display("FAIL rest_light light=%h want=01", light); end
  endtask

  task automatic test_gap_out();
    int g0 = 0, y0 = 0, first2 = -1, p1g = 0, done_at = -1;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      dem_v = (n == 5) ? 4'b0100 : 4'b0000;
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL gap_out n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      if (light[1:0] == 2'b01) g0++;
      if (light[1:0] == 2'b10) y0++;
      if (light[3:2] == 2'b01) p1g++;
      if (first2 < 0 && light[5:4] == 2'b01) first2 = n;
      if (phase_done && done_at < 0) done_at = n;
      m_adv();
    end
    total++; if (g0 !== 20) begin bad++; $display("FAIL gap_green_len got=%0d want=20", g0); end
    total++; if (y0 !== 12) begin bad++; $display("FAIL gap_yellow_len got=%0d want=12", y0); end
    total++; if (first2 !== 40) begin bad++; $display("FAIL gap_next_phase2 at=%0d want=40", first2); end
    total++; if (p1g !== 0) begin bad++; $display("FAIL gap_skip_phase1 green=%0d want=0", p1g); end
    total++; if (done_at !== 23) begin bad++; $display("FAIL gap_done at=%0d want=23", done_at); end
  endtask

  task automatic test_max_out();
    int g0 = 0, first1 = -1, w1 = 0;
    do_reset();
    for (int n = 0; n < 170; n++) begin
      dem_v = 4'b0001;
      ped_v = (n == 6) ? 4'b0010 : 4'b0000;
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL max_out n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      if (light[1:0] == 2'b01) g0++;
      if (first1 < 0 && light[3:2] == 2'b01) first1 = n;
      if (ped_walk[1]) w1++;
      m_adv();
    end
    ped_v = '0; dem_v = '0;
    total++; if (g0 !== 120) begin bad++; $display("FAIL max_green_len got=%0d want=120", g0); end
    total++; if (first1 !== 140) begin bad++; $display("FAIL max_next_phase1 at=%0d want=140", first1); end
    total++; if (w1 !== 20) begin bad++; $display("FAIL max_walk_len got=%0d want=20", w1); end
  endtask

  task automatic test_flash();
    int done_at = -1, yl = 0;
    do_reset();
    for (int n = 0; n < 90; n++) begin
      fl_v  = (n >= 12 && n < 60);
      dem_v = (n == 40) ? 4'b1000 : 4'b0000;
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL flash n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      if (phase_done && done_at < 0) done_at = n;
      if (n > 12 && n < 29 && light == 8'h02) yl++;
      if (n == 29) begin total++; if (light !== 8'hAA) begin bad++; $display("FAIL flash_first light=%h want=aa", light); end end
      if (n == 33) begin total++; if (light !== 8'hFF) begin bad++; $display("FAIL flash_dark light=%h want=ff", light); end end
      if (n == 62) begin total++; if (light !== 8'h00) begin bad++; $display("FAIL flash_allred light=%h want=00", light); end end
      if (n == 65) begin total++; if (light !== 8'h01 || active_phase !== 2'd0) begin
        bad++; $display("FAIL flash_exit_phase0 light=%h act=%0d want 01/0", light, active_phase); end end
      m_adv();
    end
    fl_v = 1'b0;
    total++; if (done_at !== 12) begin bad++; $display("FAIL flash_done at=%0d want=12", done_at); end
    total++; if (yl !== 12) begin bad++; $display("FAIL flash_yellow_len got=%0d want=12", yl); end
  endtask

  task automatic test_freeze();
    int y0 = 0, first1 = -1;
    do_reset();
    for (int n = 0; n < 140; n++) begin
      dem_v = (n == 5) ? 4'b0010 : 4'b0000;
      ped_v = (n == 40) ? 4'b1000 : 4'b0000;
      en_v  = !(n >= 28 && n < 78);
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL freeze n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      if (light[1:0] == 2'b10) y0++;
      if (first1 < 0 && light[3:2] == 2'b01) first1 = n;
      if (n == 50) begin total++; if (light !== 8'h02) begin bad++; $display("FAIL freeze_hold light=%h want=02", light); end end
      if (n == 126) begin total++; if (ped_walk !== 4'b1000) begin bad++; $display("FAIL freeze_ped_latch walk=%b want=1000", ped_walk); end end
      m_adv();
    end
    en_v = 1'b1; ped_v = '0; dem_v = '0;
    total++; if (y0 !== 62) begin bad++; $display("FAIL freeze_yellow_len got=%0d want=62", y0); end
    total++; if (first1 !== 90) begin bad++; $display("FAIL freeze_next_phase1 at=%0d want=90", first1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) fl_v = !fl_v;
      en_v  = ($urandom_range(0, 15) != 0);
      dem_v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      ped_v = ($urandom_range(0, 40) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      rst_v = ($urandom_range(0, 1499) == 0);
      cycle();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL random n=%0d got=%h exp=%h", n, got_vec, exp_vec); end
      m_adv();
    end
  endtask

  initial begin
    clock_reset = 1'b1; en = 1'b1; flash_req = 1'b0; demand = '0; ped_req = '0;
    rst_v = 1'b1; en_v = 1'b1; fl_v = 1'b0; dem_v = '0; ped_v = '0;
    test_reset();
    test_rest();
    test_gap_out();
    test_max_out();
    test_flash();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter N_PH, default 4, number of signal phases (legal 2..8).
REQ-002 Parameter TICK_DIV, default 10000, clk cycles per timing tick (1 s at the 10 kHz LF clock).
REQ-003 Parameters MIN_GREEN=5, MAX_GREEN=30, EXT=2, YELLOW=3, ALL_RED=1, all in ticks, each >=1; MIN_GREEN<=MAX_GREEN.
REQ-004 Parameter TW, default 16, width of the prescaler and all tick timers.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 clock_reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  run enable; 0 freezes prescaler, timers and state.
REQ-008 flash_req  in  1  level; requests night/flash mode.
REQ-009 demand  in  N_PH  vehicle sensor level per phase.
REQ-010 ped_req  in  N_PH  pedestrian push-button per phase, any pulse width >=1 cycle.
REQ-011 light  out  2*N_PH  code per phase, bits [2i+1:2i]: 00 red, 01 green, 10 yellow, 11 dark.
REQ-012 ped_walk  out  N_PH  walk indication per phase.
REQ-013 active_phase  out  clog2(N_PH)  phase currently owning green/yellow.
REQ-014 phase_done  out  1  one-cycle pulse on every GREEN exit.

Function
REQ-015 States: ALL_RED, GREEN, YELLOW, FLASH; state, active_phase, timers and request latches are registers; outputs decode registered state, no extra latency.
REQ-016 Prescaler counts 0..TICK_DIV-1 while en=1; tick = en and prescaler==TICK_DIV-1; prescaler clears to 0 on every state transition, so a state of duration D lasts exactly D*TICK_DIV enabled cycles.
REQ-017 State timer clears on entry, increments on tick; timed exit occurs on the tick where timer==D-1.
REQ-018 Request latch req[i] sets on any cycle with demand[i] or ped_req[i]; pedreq[i] sets on ped_req[i]; both clear on the cycle phase i enters GREEN; set dominates nothing on that cycle (entry clear wins, new input next cycle re-sets).
REQ-019 ALL_RED: all light=00; after ALL_RED ticks go GREEN of next phase: first i with req[i] searching cyclically from active_phase+1; if none, active_phase itself.
REQ-020 GREEN: light[active]=01, others 00; ped_walk[active]=1 for the first MIN_GREEN ticks if pedreq[active] was set at entry, else 0.
REQ-021 Gap timer in GREEN clears on any cycle demand[active]=1, otherwise increments on tick, saturating at EXT.
REQ-022 other_req = any req[j], j!=active; no other_req -> GREEN rests indefinitely (no max-out).
REQ-023 GREEN exits to YELLOW when other_req and green timer>=MIN_GREEN and gap timer==EXT (gap-out), or other_req and green timer==MAX_GREEN (max-out), or flash_req=1 (immediate, ignores MIN_GREEN); phase_done pulses that cycle.
REQ-024 YELLOW: light[active]=10, others 00; after YELLOW ticks -> ALL_RED.
REQ-025 ALL_RED with flash_req=1 at its timed exit -> FLASH instead of GREEN.
REQ-026 FLASH: all phases alternate 10/11 each tick, starting 10; ped_walk=0; flash_req=0 -> ALL_RED next cycle, then GREEN of phase 0 regardless of requests.
REQ-027 flash_req asserted in YELLOW or ALL_RED does not shorten them.
REQ-028 en=0: no state change, outputs hold, request latches still capture inputs.

Reset
REQ-029 clock_reset=1 forces state ALL_RED, active_phase 0, prescaler/timers 0, req/pedreq 0, light all 00, ped_walk 0, phase_done 0; overrides en and takes effect mid-state.

Verification (TICK_DIV=4, defaults otherwise, N_PH=4)
REQ-030 Reset 2 cycles, release -> light all 00 for 4 cycles, then light[1:0]=01, active_phase=0.
REQ-031 No demand/ped_req for 400 cycles after phase 0 green -> phase 0 stays 01, phase_done never pulses.
REQ-032 Pulse demand[2] while phase 0 green, demand[0]=0 -> green ends 20 cycles after entry, 12 cycles 10, 4 cycles all 00, then phase 2 green (phase 1 skipped), req[2] cleared.
REQ-033 demand[0] held 1, ped_req[1] pulsed -> phase 0 green exactly 120 cycles (max-out), then phase 1 green with ped_walk[1]=1 for 20 cycles.
REQ-034 flash_req=1 mid-green at tick 2 -> YELLOW 12, ALL_RED 4, then all codes toggle 10/11 every 4 cycles; flash_req=0 -> 4 cycles all 00, phase 0 green.
REQ-035 en=0 for 50 cycles mid-yellow -> outputs frozen; after en=1 yellow completes remaining cycles exactly.
